bep_frame_parser: RTL and testbench
===================================

BEP_FRAME_PARSER -- requirements
Module: bep_frame_parser

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 15, giving the maximum payload byte count (range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1 bit: design enable; when 0, the state machine and all registers hold.
REQ-005 The block SHALL have port sof, input, 1 bit: one-cycle start-of-frame pulse from the decoder (transmission_begin).
REQ-006 The block SHALL have port byte_valid, input, 1 bit: one-cycle pulse marking byte_in as a completed decoded byte.
REQ-007 The block SHALL have port byte_in, input, 8 bits: decoded parallel byte.
REQ-008 The block SHALL have port halt, input, 1 bit: freezes parsing.
REQ-009 The block SHALL have port rd_addr, input, 4 bits: payload buffer read index.
REQ-010 The block SHALL have port rd_data, output, 8 bits: buffer[rd_addr], combinational; 0x00 when rd_addr >= stored length.
REQ-011 The block SHALL have port frame_len, output, 4 bits: length of the last accepted frame.
REQ-012 The block SHALL have port frame_valid, output, 1 bit: sticky, last frame passed its check.
REQ-013 The block SHALL have port frame_err, output, 1 bit: sticky, last frame failed (bad length, bad checksum, or aborted).
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 States SHALL be IDLE, LEN, PAYLOAD, CHECK; the byte received in each is: LEN = length byte, PAYLOAD = payload bytes, CHECK = checksum byte.
REQ-016 sof SHALL move any state to LEN next cycle, clearing frame_valid, frame_err, the byte counter and the running checksum (0x00); sof has priority over a coincident byte_valid, which is dropped.
REQ-017 In LEN, on byte_valid: length > MAX_LEN -> frame_err=1, go to IDLE; length 0 -> go to CHECK; otherwise store the length and go to PAYLOAD.
REQ-018 In PAYLOAD, each byte_valid SHALL write buffer[count] and increment count; after the byte that makes count equal the stored length, the state SHALL go to CHECK.
REQ-019 The running checksum SHALL be the XOR of the length byte and all payload bytes, updated on the same edge the byte is accepted.
REQ-020 In CHECK, on byte_valid: byte == checksum -> frame_valid=1, frame_len=length; otherwise frame_err=1; either way go to IDLE.
REQ-021 byte_valid in IDLE SHALL be ignored.
REQ-022 While halt=1, the state, counter, checksum and buffer SHALL hold, and byte_valid SHALL be ignored; sof during halt SHALL be ignored.
REQ-023 sof arriving in LEN, PAYLOAD or CHECK (abort) SHALL set no flag, since the restart clears them; buffer contents are overwritten progressively.
REQ-024 frame_len and rd_data masking SHALL update only when a frame is accepted; frame_len holds through later failed frames.

Reset
REQ-025 On rst_n=0 at a clock edge: state=IDLE, count=0, checksum=0x00, frame_len=0, frame_valid=0, frame_err=0, busy=0, all buffer entries=0x00, so rd_data=0x00.
REQ-026 Reset asserted mid-frame SHALL discard the frame without setting frame_err.

Configuration
REQ-027 With macro BEP_CRC8_EN defined, the checksum SHALL be CRC-8 (polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR) over the length and payload bytes, computed one byte per cycle; without it, the XOR checksum of REQ-019 applies.

Structure
REQ-028 Package bep_pkg SHALL hold the state enum, the default MAX_LEN constant and the CRC polynomial constant 8'h07.
REQ-029 Sub-module bep_checksum SHALL compute next_checksum from (checksum, byte) combinationally, XOR or CRC-8 according to BEP_CRC8_EN.

Verification
REQ-030 sof; bytes 0x03,0x11,0x22,0x33,0x03 (XOR build) -> frame_valid=1, frame_len=3, rd_data at addr 0/1/2/3 = 0x11/0x22/0x33/0x00.
REQ-031 sof; bytes 0x00,0x00 -> frame_valid=1, frame_len=0 in both builds; sof; 0x10 -> frame_err=1, busy=0 the next cycle.
REQ-032 sof; 0x02,0xAA,0x55,0x00 -> frame_err=1, frame_len keeps the previous value.
REQ-033 sof; 0x02,0xAA, then sof; 0x01,0x7E,0x7F -> frame_valid=1, frame_len=1, rd_data[0]=0x7E.
REQ-034 halt=1 during PAYLOAD with two byte_valid pulses of 0xFF -> count and state unchanged; halt=0 and the remaining bytes -> frame accepted.
REQ-035 rst_n=0 mid-PAYLOAD -> all outputs at reset values on the next cycle, frame_err=0.

Source files
------------

// File: rtl/bep_pkg.sv
// Shared types and constants for the BEP frame parser.
package bep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } bep_state_e;

    localparam int         BEP_MAX_LEN_DEFAULT = 15;
    localparam logic [7:0] BEP_CRC_POLY        = 8'h07;

endpackage

// File: rtl/bep_checksum.sv
// One-byte checksum step: running XOR by default, CRC-8 (poly 0x07, MSB first)
// when BEP_CRC8_EN is defined.
module bep_checksum
    import bep_pkg::*;
(
    input  logic [7:0] csum_i,
    input  logic [7:0] byte_i,
    output logic [7:0] next_o
);

`ifdef BEP_CRC8_EN
    always_comb begin
        logic [7:0] c;
        c = csum_i ^ byte_i;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ BEP_CRC_POLY) : (c << 1);
        end
        next_o = c;
    end
`else
    assign next_o = csum_i ^ byte_i;
`endif

endmodule

// File: rtl/bep_frame_parser.sv
// Parses LEN / PAYLOAD / CHECK byte frames into a readable payload buffer.
// Checksum flavour selected by BEP_CRC8_EN (see bep_checksum).
module bep_frame_parser
    import bep_pkg::*;
#(
    parameter int MAX_LEN = BEP_MAX_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sof,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       halt,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [3:0] frame_len,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] dbg_state_o
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    bep_state_e state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] len_q, len_d;
    logic [3:0] flen_q, flen_d;
    logic [7:0] csum_q, csum_d;
    logic       fvalid_q, fvalid_d;
    logic       ferr_q, ferr_d;
    logic [7:0] buf_q [16];
    logic       wr_en;
    logic [7:0] csum_next;

    bep_checksum u_checksum (
        .csum_i (csum_q),
        .byte_i (byte_in),
        .next_o (csum_next)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        flen_d   = flen_q;
        csum_d   = csum_q;
        fvalid_d = fvalid_q;
        ferr_d   = ferr_q;
        wr_en    = 1'b0;
        // sof outranks byte_valid; halt and !ena freeze everything including sof.
        if (ena && !halt) begin
            if (sof) begin
                state_d  = ST_LEN;
                fvalid_d = 1'b0;
                ferr_d   = 1'b0;
                count_d  = 4'd0;
                csum_d   = 8'h00;
            end else if (byte_valid) begin
                case (state_q)
                    ST_LEN: begin
                        if (byte_in > MAX_LEN_B) begin
                            ferr_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            csum_d  = csum_next;
                            len_d   = byte_in[3:0];
                            state_d = (byte_in == 8'h00) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        wr_en   = 1'b1;
                        count_d = count_q + 4'd1;
                        csum_d  = csum_next;
                        if (count_q + 4'd1 == len_q) state_d = ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (byte_in == csum_q) begin
                            fvalid_d = 1'b1;
                            flen_d   = len_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= 4'd0;
            len_q    <= 4'd0;
            flen_q   <= 4'd0;
            csum_q   <= 8'h00;
            fvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            for (int i = 0; i < 16; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            len_q    <= len_d;
            flen_q   <= flen_d;
            csum_q   <= csum_d;
            fvalid_q <= fvalid_d;
            ferr_q   <= ferr_d;
            if (wr_en) buf_q[count_q] <= byte_in;
        end
    end

    // Readback is masked by the last accepted length, not the frame in flight.
    assign rd_data     = (rd_addr < flen_q) ? buf_q[rd_addr] : 8'h00;
    assign frame_len   = flen_q;
    assign frame_valid = fvalid_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bep_frame_parser.sv
// Directed and randomised frames against bep_frame_parser with an expected-result queue.
module tb_bep_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sof = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       halt = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic [3:0] frame_len;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] dbg_state;

    localparam logic [1:0] S_IDLE = 2'd0, S_LEN = 2'd1, S_PAY = 2'd2, S_CHK = 2'd3;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] exp_q[$];     // {valid, err, frame_len}
    logic [3:0] exp_len = 4'd0;

    bep_frame_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .sof         (sof),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .halt        (halt),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] model_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
`ifdef BEP_CRC8_EN
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] pl [16],
                              input bit ovr, input logic [7:0] ovr_val);
        logic [7:0] c;
        bit         ok;
        pulse_sof();
        if (len > 8'd15) begin
            exp_q.push_back({2'b01, exp_len});
            send_byte(len);
            return;
        end
        send_byte(len);
        c = model_step(8'h00, len);
        for (int i = 0; i < int'(len); i++) begin
            c = model_step(c, pl[i]);
            send_byte(pl[i]);
        end
        ok = !ovr || (ovr_val == c);
        if (ok) exp_len = len[3:0];
        exp_q.push_back({ok, !ok, exp_len});
        send_byte(ovr ? ovr_val : c);
    endtask

    task automatic check_done(input string tag);
        logic [5:0] e;
        int         budget;
        budget = 20;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_timeout"}, 8'(busy), 8'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_flags"}, 8'({frame_valid, frame_err}), 8'(e[5:4]));
            chk({tag, "_len"}, 8'(frame_len), 8'(e[3:0]));
        end
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        logic [7:0] pl [16];
        logic [7:0] c;
        int         n;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_valid", 8'(frame_valid), 8'd0);
        chk("rst_err", 8'(frame_err), 8'd0);
        chk("rst_len", 8'(frame_len), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'(S_IDLE));
        chk_rd("rst_rd0", 4'd0, 8'h00);
        rst_n = 1'b1;
        tick();

        // Zero-length frame, then over-length frame
        pl = '{default: 8'h00};
        send_frame(8'h00, pl, 1'b0, 8'h00);
        check_done("len0");
        chk_rd("len0_rd0", 4'd0, 8'h00);
        send_frame(8'h10, pl, 1'b0, 8'h00);
        chk("overlen_busy", 8'(busy), 8'd0);
        check_done("overlen");

        // Three-byte frame and readback
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h03, pl, 1'b0, 8'h00);
        check_done("len3");
        chk_rd("len3_rd0", 4'd0, 8'h11);
        chk_rd("len3_rd1", 4'd1, 8'h22);
        chk_rd("len3_rd2", 4'd2, 8'h33);
        chk_rd("len3_rd3", 4'd3, 8'h00);

        // Bad checksum keeps previous frame_len
        pl[0] = 8'hAA; pl[1] = 8'h55;
        send_frame(8'h02, pl, 1'b1, 8'h00);
        check_done("badck");

        // Abort by sof mid-payload, then a good one-byte frame
        pulse_sof();
        send_byte(8'h02);
        send_byte(8'hAA);
        chk("abort_state_before", 8'(dbg_state), 8'(S_PAY));
        pl[0] = 8'h7E;
        send_frame(8'h01, pl, 1'b0, 8'h00);
        check_done("abort");
        chk_rd("abort_rd0", 4'd0, 8'h7E);
        chk_rd("abort_rd1", 4'd1, 8'h00);

        // Halt freezes payload, sof and byte_valid
        pulse_sof();
        send_byte(8'h03);
        send_byte(8'h10);
        halt = 1'b1;
        send_byte(8'hFF);
        send_byte(8'hFF);
        pulse_sof();
        chk("halt_state", 8'(dbg_state), 8'(S_PAY));
        chk("halt_busy", 8'(busy), 8'd1);
        halt = 1'b0;
        send_byte(8'h20);
        send_byte(8'h30);
        chk("halt_to_check", 8'(dbg_state), 8'(S_CHK));
        c = model_step(model_step(model_step(model_step(8'h00, 8'h03), 8'h10), 8'h20), 8'h30);
        exp_len = 4'd3;
        exp_q.push_back({2'b10, exp_len});
        send_byte(c);
        check_done("halt");
        chk_rd("halt_rd0", 4'd0, 8'h10);
        chk_rd("halt_rd1", 4'd1, 8'h20);
        chk_rd("halt_rd2", 4'd2, 8'h30);

        // ena=0 holds the FSM
        pulse_sof();
        send_byte(8'h01);
        ena = 1'b0;
        send_byte(8'h55);
        chk("ena_hold_state", 8'(dbg_state), 8'(S_PAY));
        ena = 1'b1;
        send_byte(8'h66);
        chk("ena_resume_state", 8'(dbg_state), 8'(S_CHK));
        exp_len = 4'd1;
        exp_q.push_back({2'b10, exp_len});
        send_byte(model_step(model_step(8'h00, 8'h01), 8'h66));
        check_done("ena");
        chk_rd("ena_rd0", 4'd0, 8'h66);

        // byte_valid in IDLE ignored
        send_byte(8'h01);
        chk("idle_ignore_state", 8'(dbg_state), 8'(S_IDLE));

        // sof beats a coincident byte_valid
        sof = 1'b1;
        byte_in = 8'h00;
        byte_valid = 1'b1;
        tick();
        sof = 1'b0;
        byte_valid = 1'b0;
        chk("sof_prio_state", 8'(dbg_state), 8'(S_LEN));
        chk("sof_clears_valid", 8'(frame_valid), 8'd0);

        // Reset mid-payload
        send_byte(8'h03);
        send_byte(8'h11);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_err", 8'(frame_err), 8'd0);
        chk("midrst_valid", 8'(frame_valid), 8'd0);
        chk("midrst_len", 8'(frame_len), 8'd0);
        chk_rd("midrst_rd0", 4'd0, 8'h00);
        exp_len = 4'd0;

        // Random frames, some with corrupted checksum
        for (int f = 0; f < 8; f++) begin
            bit bad;
            n = $urandom_range(1, 15);
            bad = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
            c = model_step(8'h00, 8'(n));
            for (int i = 0; i < n; i++) c = model_step(c, pl[i]);
            send_frame(8'(n), pl, bad, bad ? ~c : c);
            check_done("rand");
            if (!bad) begin
                for (int i = 0; i < 16; i++)
                    chk_rd("rand_rd", 4'(i), (i < n) ? pl[i] : 8'h00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
